// File: rtl/ospi_controller.sv
// Octal-SPI SDR initiator: turns one host command into a CMD/ADDR/[DUMMY]/DATA frame
// on the OSPI pads, with a guaranteed chip-select high gap between frames.
module ospi_controller #(
    parameter int CLK_DIV = 2,
    parameter int DUMMY   = 2,
    parameter int CS_HIGH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic       cmd_cs,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       done,
    output logic       err,
    output logic [7:0] rsp_rdata,
    output logic       OSPI_CLK,
    output logic       OSPI_CS0_b,
    output logic       OSPI_CS1_b,
    output logic       OSPI_RST_b,
    inout  wire  [7:0] OSPI_IO
);

    localparam int BEAT = 2 * CLK_DIV;
    localparam int CMAX = (BEAT > CS_HIGH) ? BEAT : CS_HIGH;
    localparam int CW   = $clog2(CMAX) + 1;
    localparam int BW   = $clog2(DUMMY) + 1;

    localparam logic [CW-1:0] BEAT_LAST  = CW'(BEAT - 1);
    localparam logic [CW-1:0] HALF       = CW'(CLK_DIV);
    localparam logic [CW-1:0] GAP_LAST   = CW'((CS_HIGH > 1) ? CS_HIGH - 2 : 0);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [BW-1:0] DUMMY_LAST = BW'(DUMMY - 1);
    localparam logic [BW-1:0] BEAT_ONE   = BW'(1);

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_ERASE = 2'd2;
    localparam logic [1:0] OP_ILL   = 2'd3;

    typedef enum logic [3:0] {
        S_RST, S_IDLE, S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA, S_END, S_GAP
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [BW-1:0] r_beat;
    logic [1:0]    r_op;
    logic          r_cs;
    logic [7:0]    r_addr;
    logic [7:0]    r_wdata;
    logic [7:0]    r_rdata;
    logic          w_in_beat;
    logic          w_beat_end;
    logic          w_io_oe;
    logic [7:0]    w_opcode;
    logic [7:0]    w_io_out;

    assign w_in_beat  = r_state inside {S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA};
    assign w_beat_end = w_in_beat && (r_cnt == BEAT_LAST);
    assign w_io_oe    = r_state inside {S_CMD, S_ADDR, S_WDATA};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RST:   w_next = S_IDLE;
            S_IDLE:  if (cmd_valid) w_next = (cmd_op == OP_ILL) ? S_END : S_CMD;
            S_CMD:   if (w_beat_end) w_next = S_ADDR;
            S_ADDR: begin
                if (w_beat_end) begin
                    case (r_op)
                        OP_READ:  w_next = S_DUMMY;
                        OP_WRITE: w_next = S_WDATA;
                        default:  w_next = S_END;
                    endcase
                end
            end
            S_WDATA: if (w_beat_end) w_next = S_END;
            S_DUMMY: if (w_beat_end && r_beat == DUMMY_LAST) w_next = S_RDATA;
            S_RDATA: if (w_beat_end) w_next = S_END;
            S_END:   w_next = (CS_HIGH > 1) ? S_GAP : S_IDLE;
            S_GAP:   if (r_cnt == GAP_LAST) w_next = S_IDLE;
            default: w_next = S_RST;
        endcase
    end

    // r_cnt times cycles within a beat, or within the CS gap after END.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RST;
            r_cnt   <= '0;
            r_beat  <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state != w_next || w_beat_end || r_state == S_IDLE)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CNT_ONE;
            if (r_state != S_DUMMY)
                r_beat <= '0;
            else if (w_beat_end)
                r_beat <= r_beat + BEAT_ONE;
            if (r_state == S_RDATA && w_beat_end)
                r_rdata <= OSPI_IO;
        end
    end

    // NOTE: command fields need no reset; they are only read after an accept loads them.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && cmd_valid) begin
            r_op    <= cmd_op;
            r_cs    <= cmd_cs;
            r_addr  <= cmd_addr;
            r_wdata <= cmd_wdata;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_opcode = 8'h00;
        case (r_op)
            OP_READ:  w_opcode = 8'h03;
            OP_WRITE: w_opcode = 8'h02;
            OP_ERASE: w_opcode = 8'h20;
            default:  w_opcode = 8'h00;
        endcase
        w_io_out = 8'h00;
        case (r_state)
            S_CMD:   w_io_out = w_opcode;
            S_ADDR:  w_io_out = r_addr;
            S_WDATA: w_io_out = r_wdata;
            default: w_io_out = 8'h00;
        endcase
    end

    assign OSPI_IO    = w_io_oe ? w_io_out : 8'hzz;
    assign OSPI_CLK   = w_in_beat && (r_cnt >= HALF);
    assign OSPI_CS0_b = !(w_in_beat && !r_cs);
    assign OSPI_CS1_b = !(w_in_beat && r_cs);
    assign OSPI_RST_b = (r_state != S_RST);
    assign cmd_ready  = (r_state == S_IDLE);
    assign done       = (r_state == S_END);
    assign err        = (r_state == S_END) && (r_op == OP_ILL);
    assign rsp_rdata  = r_rdata;

endmodule
